mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the pipeline's instruction-fetch port (read-only)
//  and the MEM-stage data port (load/store). One memory transaction is outstanding at a time.
//  Data wins by default; a starvation guard forces a fetch grant after MAX_DATA_WINS data wins.
//  Requester acks drive the fetch/MEM stall logic in top.
// PARAMETERS
//  ADDR_W         32   address width, both ports and memory
//  DATA_W         32   data width
//  MAX_DATA_WINS  4    consecutive data grants with fetch pending before fetch is forced (>=1)
//  TIMEOUT        256  cycles without mem ack before abort (MEM_ARB_TIMEOUT_EN only)
// PORTS
//  clk              in   1          clock, rising edge
//  reset            in   1          asynchronous, active-low reset
//  fetch_req_arb_i  in   1          fetch read request; held until fetch_ack_arb_o
//  fetch_addr_arb_i in   ADDR_W     fetch address; stable while req high
//  fetch_ack_arb_o  out  1          1-cycle pulse: fetch done, fetch_rdata valid
//  fetch_rdata_arb_o out DATA_W     instruction word; valid only with fetch_ack
//  data_req_arb_i   in   1          data request; held until data_ack_arb_o
//  data_we_arb_i    in   1          1=store, 0=load
//  data_addr_arb_i  in   ADDR_W     data address
//  data_wdata_arb_i in   DATA_W     store data
//  data_strb_arb_i  in   DATA_W/8   byte strobes for stores
//  data_ack_arb_o   out  1          1-cycle pulse: data done
//  data_rdata_arb_o out  DATA_W     load data; valid only with data_ack
//  mem_req_arb_o    out  1          registered; high from grant until mem_ack_arb_i
//  mem_we_arb_o     out  1          registered write enable
//  mem_addr_arb_o   out  ADDR_W     registered address
//  mem_wdata_arb_o  out  DATA_W     registered write data
//  mem_strb_arb_o   out  DATA_W/8   registered strobes (4'h0 on fetch)
//  mem_ack_arb_i    in   1          memory completion; rdata valid same cycle
//  mem_rdata_arb_i  in   DATA_W     memory read data
//  err_arb_o        out  1          1-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; mem_req/we/addr/wdata/strb=0; data_wins=0; all acks and err=0.
//  - FSM: IDLE -> DATA_BUSY | FETCH_BUSY on grant; BUSY -> IDLE on mem_ack_arb_i (or timeout).
//  - IDLE, cycle N: sample requests. Only fetch -> fetch. Only data -> data.
//    Both -> fetch if data_wins==MAX_DATA_WINS, else data.
//    Grant latches addr/we/wdata/strb; mem_req_arb_o=1 from N+1.
//  - Grant in IDLE is independent of mem_ack_arb_i. mem_ack_arb_i in IDLE is ignored.
//  - BUSY: the owner's ack is combinational: ack_o = mem_ack_arb_i & (state==owner).
//    rdata_o = mem_rdata_arb_i; rdata_o is 0 when its ack is low.
//    mem_req_arb_o drops the next cycle; the FSM is in IDLE the next cycle.
//  - Zero-wait memory: 1 transaction per 2 cycles. Requester may re-request in the cycle after its ack.
//  - Starvation counter data_wins (width $clog2(MAX_DATA_WINS+1)), updated at grant:
//    +1 on a data grant while fetch_req is high (saturating); cleared on a fetch grant.
//    Unchanged on a data grant with no fetch pending.
//  - Requests deasserted mid-BUSY are a protocol violation; the transaction still completes and acks.
//  - Reset mid-transaction: immediate return to IDLE. A late mem_ack after reset release is ignored.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - Counter runs in BUSY states.
//   - If it reaches TIMEOUT without mem_ack: next cycle mem_req=0, owner ack=1 with rdata=0,
//     err_arb_o=1, state -> IDLE. data_wins is not changed by the abort.
//   - Counter clears on entry to BUSY.
//  MEM_ARB_TIMEOUT_EN undefined:
//   - No counter; BUSY waits indefinitely.
//   - err_arb_o is tied 0; the port is always present.
// STRUCTURE
//  - Shared package mem_arb_pkg: state encoding ARB_IDLE/ARB_DATA_BUSY/ARB_FETCH_BUSY,
//    owner encoding OWN_FETCH/OWN_DATA.
//  - One sub-module, arb_timeout_cnt (clear/enable/expire), instantiated only under MEM_ARB_TIMEOUT_EN.
//  - FSM, starvation counter and request latches stay in mem_arbiter.
// TESTING
//  1. Single fetch, addr 0x100, zero-wait memory returning 0x2402000A:
//     mem_req high 1 cycle after req; fetch_ack same cycle as mem_ack with rdata 0x2402000A.
//  2. Fetch and data (store 0xCAFEF00D @0x40, strb F) raised together:
//     data granted first (mem_we=1); fetch granted 2 cycles later.
//  3. Fetch held continuously, data re-requests after each ack, MAX_DATA_WINS=4:
//     grant order D,D,D,D,F,D,...; data_wins returns to 0 after F.
//  4. Memory ack delayed 5 cycles:
//     mem_req held 5 cycles; no requester ack early; no second grant while BUSY.
//  5. Reset asserted while DATA_BUSY, then mem_ack pulses after release:
//     outputs 0 at reset; stray ack produces no data_ack.
//  6. MEM_ARB_TIMEOUT_EN, TIMEOUT=8, memory never acks a load:
//     after 8 BUSY cycles, data_ack=1, rdata=0, err_arb_o pulses once, FSM in IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the unified-memory arbiter
// Purpose: FSM state and transaction-owner encodings used by mem_arbiter and its bench.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_DATA_BUSY  = 2'd1,
    ARB_FETCH_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - busy-cycle counter that flags a memory timeout
// Purpose: counts enabled cycles since the last clear; expire is high in the
//          TIMEOUT-th enabled cycle so the owner can abort on the following edge.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   clear       hold count at zero (asserted whenever no transaction is in flight)
//   enable      count this cycle (busy and no memory ack)
//   expire      combinational: this is the TIMEOUT-th enabled cycle
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = enable && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-ported unified memory
// Purpose: one transaction outstanding at a time; data wins by default, a
//          starvation guard forces a fetch grant after MAX_DATA_WINS data wins.
// Optional feature: MEM_ARB_TIMEOUT_EN adds a busy timeout that aborts the
//          transaction, acks the owner with zero data and pulses err_arb_o.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   fetch_*_arb_i / _o         instruction-fetch read port (req/addr in, ack/rdata out)
//   data_*_arb_i / _o          MEM-stage load/store port (req/we/addr/wdata/strb in, ack/rdata out)
//   mem_*_arb_o                registered memory request bundle
//   mem_ack_arb_i, mem_rdata   memory completion and read data (same cycle)
//   err_arb_o                  timeout abort pulse (tied 0 without the timeout feature)
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DATA_WINS = 4,
  parameter int unsigned TIMEOUT       = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_req_arb_i,
  input  logic [ADDR_W-1:0]   fetch_addr_arb_i,
  output logic                fetch_ack_arb_o,
  output logic [DATA_W-1:0]   fetch_rdata_arb_o,
  input  logic                data_req_arb_i,
  input  logic                data_we_arb_i,
  input  logic [ADDR_W-1:0]   data_addr_arb_i,
  input  logic [DATA_W-1:0]   data_wdata_arb_i,
  input  logic [DATA_W/8-1:0] data_strb_arb_i,
  output logic                data_ack_arb_o,
  output logic [DATA_W-1:0]   data_rdata_arb_o,
  output logic                mem_req_arb_o,
  output logic                mem_we_arb_o,
  output logic [ADDR_W-1:0]   mem_addr_arb_o,
  output logic [DATA_W-1:0]   mem_wdata_arb_o,
  output logic [DATA_W/8-1:0] mem_strb_arb_o,
  input  logic                mem_ack_arb_i,
  input  logic [DATA_W-1:0]   mem_rdata_arb_i,
  output logic                err_arb_o
);

  localparam int unsigned WINS_W = $clog2(MAX_DATA_WINS + 1);
  localparam logic [WINS_W-1:0] WINS_MAX = WINS_W'(MAX_DATA_WINS);

  arb_state_t        state;
  arb_owner_t        owner;
  logic [WINS_W-1:0] data_wins;
  logic              abort_q;   // high for the one IDLE cycle that follows a timeout abort
  logic              expire;
  logic              can_grant;
  logic              grant_fetch;
  logic              grant_data;
  logic              fetch_done;
  logic              data_done;

  // The abort cycle is reserved for the abort ack: the owner's request is still
  // high there and must not be re-granted before it sees the ack.
  assign can_grant   = (state == ARB_IDLE) && !abort_q;
  assign grant_fetch = can_grant && fetch_req_arb_i &&
                       (!data_req_arb_i || (data_wins == WINS_MAX));
  assign grant_data  = can_grant && data_req_arb_i && !grant_fetch;

  assign fetch_done = (state == ARB_FETCH_BUSY) && mem_ack_arb_i;
  assign data_done  = (state == ARB_DATA_BUSY) && mem_ack_arb_i;

  assign fetch_ack_arb_o   = fetch_done || (abort_q && (owner == OWN_FETCH));
  assign data_ack_arb_o    = data_done  || (abort_q && (owner == OWN_DATA));
  assign fetch_rdata_arb_o = fetch_done ? mem_rdata_arb_i : '0;
  assign data_rdata_arb_o  = data_done  ? mem_rdata_arb_i : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ARB_IDLE),
    .enable ((state != ARB_IDLE) && !mem_ack_arb_i),
    .expire (expire)
  );
  assign err_arb_o = abort_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire         = 1'b0;
  assign err_arb_o      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ARB_IDLE;
      owner           <= OWN_FETCH;
      data_wins       <= '0;
      abort_q         <= 1'b0;
      mem_req_arb_o   <= 1'b0;
      mem_we_arb_o    <= 1'b0;
      mem_addr_arb_o  <= '0;
      mem_wdata_arb_o <= '0;
      mem_strb_arb_o  <= '0;
    end else begin
      abort_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_fetch) begin
            state           <= ARB_FETCH_BUSY;
            owner           <= OWN_FETCH;
            data_wins       <= '0;
            mem_req_arb_o   <= 1'b1;
            mem_we_arb_o    <= 1'b0;
            mem_addr_arb_o  <= fetch_addr_arb_i;
            mem_wdata_arb_o <= '0;
            mem_strb_arb_o  <= '0;
          end else if (grant_data) begin
            state           <= ARB_DATA_BUSY;
            owner           <= OWN_DATA;
            mem_req_arb_o   <= 1'b1;
            mem_we_arb_o    <= data_we_arb_i;
            mem_addr_arb_o  <= data_addr_arb_i;
            mem_wdata_arb_o <= data_wdata_arb_i;
            mem_strb_arb_o  <= data_strb_arb_i;
            // Only a win over a waiting fetch counts towards starvation.
            if (fetch_req_arb_i && (data_wins != WINS_MAX)) begin
              data_wins <= data_wins + WINS_W'(1);
            end
          end
        end
        default: begin
          if (mem_ack_arb_i) begin
            state         <= ARB_IDLE;
            mem_req_arb_o <= 1'b0;
          end else if (expire) begin
            state         <= ARB_IDLE;
            mem_req_arb_o <= 1'b0;
            abort_q       <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_strb = '0;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .MAX_DATA_WINS (4),
    .TIMEOUT       (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_req_arb_i   (fetch_req),
    .fetch_addr_arb_i  (fetch_addr),
    .fetch_ack_arb_o   (fetch_ack),
    .fetch_rdata_arb_o (fetch_rdata),
    .data_req_arb_i    (data_req),
    .data_we_arb_i     (data_we),
    .data_addr_arb_i   (data_addr),
    .data_wdata_arb_i  (data_wdata),
    .data_strb_arb_i   (data_strb),
    .data_ack_arb_o    (data_ack),
    .data_rdata_arb_o  (data_rdata),
    .mem_req_arb_o     (mem_req),
    .mem_we_arb_o      (mem_we),
    .mem_addr_arb_o    (mem_addr),
    .mem_wdata_arb_o   (mem_wdata),
    .mem_strb_arb_o    (mem_strb),
    .mem_ack_arb_i     (mem_ack),
    .mem_rdata_arb_i   (mem_rdata),
    .err_arb_o         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [5:0] exp_data_grant;
  int         exp_wins [6];

  initial begin
    // Reset state
    tick(); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_strb", mem_strb, 0);
    chk("rst_acks", {fetch_ack, data_ack, err}, 0);
    chk("rst_state", dut.state, ARB_IDLE);
    tick(); reset = 1'b1;

    // 1. single fetch, zero-wait memory
    tick(); fetch_req = 1'b1; fetch_addr = 32'h100; #1;
    chk("t1_req_cycle_n", mem_req, 0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h2402000A; #1;
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we_strb", {mem_we, mem_strb}, 0);
    chk("t1_fetch_ack", fetch_ack, 1);
    chk("t1_fetch_rdata", fetch_rdata, 32'h2402000A);
    chk("t1_data_ack", data_ack, 0);
    tick(); fetch_req = 1'b0; mem_ack = 1'b0; #1;
    chk("t1_req_drop", mem_req, 0);
    chk("t1_rdata_gated", fetch_rdata, 0);

    // 2. fetch and store raised together: data first, fetch two cycles later
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h200;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40;
    data_wdata = 32'hCAFEF00D; data_strb = 4'hF; #1;
    tick(); mem_ack = 1'b1; mem_rdata = 32'h0; #1;
    chk("t2_data_we", mem_we, 1);
    chk("t2_data_addr", mem_addr, 32'h40);
    chk("t2_data_wdata", mem_wdata, 32'hCAFEF00D);
    chk("t2_data_strb", mem_strb, 4'hF);
    chk("t2_acks", {data_ack, fetch_ack}, 2'b10);
    tick(); data_req = 1'b0; mem_ack = 1'b0; #1;
    chk("t2_idle_gap", mem_req, 0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h11111111; #1;
    chk("t2_fetch_addr", mem_addr, 32'h200);
    chk("t2_fetch_strb", {mem_we, mem_strb}, 0);
    chk("t2_fetch_acks", {data_ack, fetch_ack}, 2'b01);
    chk("t2_fetch_rdata", fetch_rdata, 32'h11111111);
    tick(); fetch_req = 1'b0; mem_ack = 1'b0; #1;

    // 3. starvation guard: D,D,D,D,F,D with both requests always high
    exp_data_grant = 6'b101111;
    exp_wins = '{1, 2, 3, 4, 0, 1};
    tick();
    fetch_req = 1'b1; fetch_addr = 32'h300;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80;
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA; #1;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      chk("t3_mem_req", mem_req, 1);
      chk("t3_grant", {data_ack, fetch_ack}, exp_data_grant[k] ? 2'b10 : 2'b01);
      chk("t3_data_wins", dut.data_wins, exp_wins[k]);
      tick();
      if (k == 5) begin
        fetch_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
      end
      #1;
      chk("t3_idle", mem_req, 0);
    end

    // 4. memory ack delayed: request held, no early ack, no regrant
    tick(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h44;
    mem_rdata = 32'hDEADBEEF; #1;
    tick(); #1;
    chk("t4_req_c1", mem_req, 1);
    for (int i = 1; i < 5; i++) begin
      tick();
      if (i == 1) begin
        fetch_req = 1'b1; fetch_addr = 32'h500;
      end
      #1;
      chk("t4_req_held", mem_req, 1);
      chk("t4_no_ack", {data_ack, fetch_ack}, 0);
      chk("t4_rdata_gated", data_rdata, 0);
      chk("t4_no_regrant", mem_addr, 32'h44);
    end
    tick(); mem_ack = 1'b1; #1;
    chk("t4_data_ack", data_ack, 1);
    chk("t4_data_rdata", data_rdata, 32'hDEADBEEF);
    chk("t4_wins_kept", dut.data_wins, 1);
    tick(); data_req = 1'b0; mem_ack = 1'b0; #1;
    chk("t4_idle", mem_req, 0);
    tick(); mem_ack = 1'b1; #1;
    chk("t4_fetch_after", {fetch_ack, mem_addr}, {1'b1, 32'h500});
    tick(); fetch_req = 1'b0; mem_ack = 1'b0; #1;

    // 5. reset while DATA_BUSY, stray ack afterwards
    tick(); data_req = 1'b1; data_we = 1'b1; data_addr = 32'h60;
    data_wdata = 32'h12345678; data_strb = 4'h3; #1;
    tick(); #1;
    chk("t5_busy", {mem_req, mem_we}, 2'b11);
    reset = 1'b0; data_req = 1'b0; #1;
    chk("t5_async_req", mem_req, 0);
    chk("t5_async_bus", {mem_we, mem_addr, mem_wdata, mem_strb}, 0);
    chk("t5_async_state", dut.state, ARB_IDLE);
    tick(); reset = 1'b1;
    tick(); mem_ack = 1'b1; #1;
    chk("t5_stray_ack", {data_ack, fetch_ack, mem_req}, 0);
    tick(); mem_ack = 1'b0; #1;
    chk("t5_no_grant", mem_req, 0);
    chk("t5_err_low", err, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // 6. timeout abort on a load that memory never acks
    tick(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h70;
    mem_rdata = 32'hA5A5A5A5; #1;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      chk("t6_busy_req", mem_req, 1);
      chk("t6_busy_quiet", {data_ack, err}, 0);
    end
    tick(); #1;
    chk("t6_abort_req", mem_req, 0);
    chk("t6_abort_ack", data_ack, 1);
    chk("t6_abort_rdata", data_rdata, 0);
    chk("t6_abort_err", err, 1);
    chk("t6_abort_state", dut.state, ARB_IDLE);
    tick(); data_req = 1'b0; #1;
    chk("t6_after", {err, data_ack, mem_req}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
